// File: rtl/pcpi_loader_pkg.sv
// Shared types and sizing for the PCPI instruction loader.
package pcpi_loader_pkg;

  localparam int NIB_W_DEF  = 4;
  localparam int INSN_W_DEF = 32;
  localparam int NIBBLES    = INSN_W_DEF / NIB_W_DEF;
  localparam int CNT_W      = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_shift_reg.sv
// Word register with nibble write-at-index, full-word load and nibble read-at-index.
module nibble_shift_reg
  import pcpi_loader_pkg::*;
#(
  parameter int DATA_W = INSN_W_DEF,
  parameter int NIB_W  = NIB_W_DEF
) (
  input  logic                              clk,
  input  logic                              clr,
  input  logic                              wr_en,
  input  logic [$clog2(DATA_W/NIB_W)-1:0]   wr_idx,
  input  logic [NIB_W-1:0]                  wr_nib,
  input  logic                              ld_en,
  input  logic [DATA_W-1:0]                 ld_data,
  input  logic [$clog2(DATA_W/NIB_W)-1:0]   rd_idx,
  output logic [NIB_W-1:0]                  rd_nib,
  output logic [DATA_W-1:0]                 q
);

  // Word storage: clear wins, then full load, then single-nibble write
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (ld_en) begin
      q <= ld_data;
    end else if (wr_en) begin
      q[wr_idx*NIB_W +: NIB_W] <= wr_nib;
    end
  end

  // Nibble read mux
  always_comb begin
    rd_nib = q[rd_idx*NIB_W +: NIB_W];
  end

endmodule

// File: rtl/pcpi_insn_loader.sv
// Nibble-serial front end for a PCPI coprocessor: assembles an instruction
// from pin nibbles, issues it with the valid/ready handshake, and returns a
// written-back result as nibbles.
// Optional build macro PCPI_LOADER_TIMEOUT_EN adds an ISSUE-state timeout
// with a sticky err flag.
module pcpi_insn_loader
  import pcpi_loader_pkg::*;
#(
  parameter int NIB_W   = NIB_W_DEF,
  parameter int INSN_W  = INSN_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nib_valid,
  input  logic [NIB_W-1:0]  nib_data,
  output logic              nib_ready,
  output logic              pcpi_valid,
  output logic [INSN_W-1:0] pcpi_insn,
  input  logic              pcpi_ready,
  input  logic              pcpi_wr,
  input  logic              pcpi_wait,
  input  logic [INSN_W-1:0] pcpi_rd,
  output logic              res_valid,
  output logic [NIB_W-1:0]  res_data,
  input  logic              res_ready,
  output logic              busy,
  output logic              err
);

  localparam int NIBS = INSN_W / NIB_W;
  localparam int IDX_W = $clog2(NIBS);
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(NIBS - 1);

  if ((INSN_W % NIB_W) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("pcpi_insn_loader: INSN_W must be a multiple of NIB_W and TIMEOUT >= 1");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic             insn_wr;
  logic             res_ld;
  logic             err_set;
  logic             unused_wait;
  logic [NIB_W-1:0] unused_insn_nib;
  logic [INSN_W-1:0] unused_res_word;

  // pcpi_wait is status only; the handshake is driven purely by pcpi_ready
  assign unused_wait = pcpi_wait;

  nibble_shift_reg #(.DATA_W(INSN_W), .NIB_W(NIB_W)) u_insn (
    .clk     (clk),
    .clr     (rst),
    .wr_en   (insn_wr),
    .wr_idx  (count_q),
    .wr_nib  (nib_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .rd_idx  (count_q),
    .rd_nib  (unused_insn_nib),
    .q       (pcpi_insn)
  );

  nibble_shift_reg #(.DATA_W(INSN_W), .NIB_W(NIB_W)) u_result (
    .clk     (clk),
    .clr     (rst),
    .wr_en   (1'b0),
    .wr_idx  ('0),
    .wr_nib  ('0),
    .ld_en   (res_ld),
    .ld_data (pcpi_rd),
    .rd_idx  (count_q),
    .rd_nib  (res_data),
    .q       (unused_res_word)
  );

`ifdef PCPI_LOADER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] timer_q;
  logic             err_q;

  // ISSUE-cycle counter; restarts every time ISSUE is entered
  always_ff @(posedge clk) begin
    if (rst || state_q != ISSUE) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // State and nibble counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic and per-state strobes
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    insn_wr = 1'b0;
    res_ld  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      LOAD: begin
        if (nib_valid) begin
          insn_wr = 1'b1;
          if (count_q == CNT_LAST) begin
            count_d = '0;
            state_d = ISSUE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (pcpi_ready) begin
          if (pcpi_wr) begin
            res_ld  = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = LOAD;
          end
        end
`ifdef PCPI_LOADER_TIMEOUT_EN
        else if (timer_q == TMR_LAST) begin
          err_set = 1'b1;
          state_d = LOAD;
        end
`endif
      end
      DRAIN: begin
        if (res_ready) begin
          if (count_q == CNT_LAST) begin
            count_d = '0;
            state_d = LOAD;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        count_d = '0;
      end
    endcase
  end

  // Handshake outputs are pure decodes of the registered state
  always_comb begin
    nib_ready  = (state_q == LOAD);
    pcpi_valid = (state_q == ISSUE);
    res_valid  = (state_q == DRAIN);
    busy       = !((state_q == LOAD) && (count_q == '0));
  end

endmodule
